// File: rtl/mealy_pkg.sv
// ============================================================================
// Module      : mealy_pkg
// Description : Shared types and constants for the Mealy output-code tracker.
//               State encoding of the observed 4-state machine, the seven
//               legal transition output codes, the illegal code, and the
//               tracker control-mode encoding.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package mealy_pkg;

    // States of the observed source machine
    typedef enum logic [1:0] {
        ST_A = 2'b00,
        ST_B = 2'b01,
        ST_C = 2'b10,
        ST_D = 2'b11
    } mealy_state_t;

    // Tracker control mode
    typedef enum logic [0:0] {
        TRK_LOCKED = 1'b0,
        TRK_HUNT   = 1'b1
    } trk_mode_t;

    // Transition output codes, named <source state><input bit>
    localparam logic [2:0] CODE_A0      = 3'b111;  // A --0--> B
    localparam logic [2:0] CODE_A1      = 3'b101;  // A --1--> C
    localparam logic [2:0] CODE_B0      = 3'b001;  // B --0--> D
    localparam logic [2:0] CODE_B1      = 3'b011;  // B --1--> A
    localparam logic [2:0] CODE_C0      = 3'b000;  // C --0--> B
    localparam logic [2:0] CODE_C1      = 3'b100;  // C --1--> D
    localparam logic [2:0] CODE_D       = 3'b110;  // D --x--> D
    localparam logic [2:0] CODE_ILLEGAL = 3'b010;

    // Width of the hunt run counter; holds LOCK_CNT values up to 15
    localparam int unsigned RUN_W = 4;

endpackage : mealy_pkg

`default_nettype wire

// File: rtl/mealy_code_lookup.sv
// ============================================================================
// Module      : mealy_code_lookup
// Description : Combinational decoder for one observed output code. Every
//               legal code maps uniquely to its source state, the input bit
//               that caused it and the resulting next state.
// Ports       : code_i        - observed 3-bit output code
//               legal_o       - code is one of the seven legal codes
//               src_state_o   - state the source machine was in
//               in_bit_o      - recovered input bit (0 when unknown)
//               in_known_o    - input bit is determinate (0 only for D)
//               nxt_state_o   - state the source machine moved to
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mealy_code_lookup
    import mealy_pkg::*;
(
    input  logic [2:0]   code_i,
    output logic         legal_o,
    output mealy_state_t src_state_o,
    output logic         in_bit_o,
    output logic         in_known_o,
    output mealy_state_t nxt_state_o
);

    always_comb begin
        legal_o     = 1'b1;
        src_state_o = ST_A;
        in_bit_o    = 1'b0;
        in_known_o  = 1'b1;
        nxt_state_o = ST_A;
        case (code_i)
            CODE_A0: begin src_state_o = ST_A; in_bit_o = 1'b0; nxt_state_o = ST_B; end
            CODE_A1: begin src_state_o = ST_A; in_bit_o = 1'b1; nxt_state_o = ST_C; end
            CODE_B0: begin src_state_o = ST_B; in_bit_o = 1'b0; nxt_state_o = ST_D; end
            CODE_B1: begin src_state_o = ST_B; in_bit_o = 1'b1; nxt_state_o = ST_A; end
            CODE_C0: begin src_state_o = ST_C; in_bit_o = 1'b0; nxt_state_o = ST_B; end
            CODE_C1: begin src_state_o = ST_C; in_bit_o = 1'b1; nxt_state_o = ST_D; end
            CODE_D: begin
                // D self-loops on either input with the same code, so the
                // bit cannot be recovered.
                src_state_o = ST_D;
                in_known_o  = 1'b0;
                nxt_state_o = ST_D;
            end
            default: begin
                legal_o    = 1'b0;
                in_known_o = 1'b0;
            end
        endcase
    end

endmodule : mealy_code_lookup

`default_nettype wire

// File: rtl/mealy_out_tracker.sv
// ============================================================================
// Module      : mealy_out_tracker
// Description : Observer for the 4-state Mealy sequence machine. Follows the
//               stream of output codes, reconstructs the source state,
//               recovers the input bit of each transition, flags illegal or
//               inconsistent codes and re-acquires lock after an error.
// Parameters  : LOCK_CNT - consecutive consistent legal codes to regain lock
//                          (1..15)
//               CNT_W    - width of the statistics counters
// Ports       : clk, reset_n (synchronous, active-low)
//               code_valid, code[2:0], resync        - inputs
//               bit_valid, bit_out, bit_known, err   - registered results
//               locked, state_q[1:0]                 - registered status
//               bit_cnt, err_cnt [CNT_W-1:0]         - statistics, only when
//                                                      MEALY_TRK_STATS_EN is
//                                                      defined
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mealy_out_tracker
    import mealy_pkg::*;
#(
    parameter int unsigned LOCK_CNT = 2,
    parameter int unsigned CNT_W    = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             code_valid,
    input  logic [2:0]       code,
    input  logic             resync,
    output logic             bit_valid,
    output logic             bit_out,
    output logic             bit_known,
    output logic             err,
    output logic             locked,
    output logic [1:0]       state_q
`ifdef MEALY_TRK_STATS_EN
    ,
    output logic [CNT_W-1:0] bit_cnt,
    output logic [CNT_W-1:0] err_cnt
`endif
);

    localparam logic [RUN_W-1:0] c_LOCK_CNT = RUN_W'(LOCK_CNT);

    // ------------------------------------------------------------------
    // Registers and next-state values
    // ------------------------------------------------------------------
    trk_mode_t         mode_q,      mode_d;
    logic [RUN_W-1:0]  run_q,       run_d;
    mealy_state_t      trk_state_q, trk_state_d;
    logic              bit_valid_q, bit_valid_d;
    logic              bit_out_q,   bit_out_d;
    logic              bit_known_q, bit_known_d;
    logic              err_q,       err_d;

    // ------------------------------------------------------------------
    // Code decode
    // ------------------------------------------------------------------
    logic              w_legal;
    mealy_state_t      w_src;
    logic              w_in_bit;
    logic              w_in_known;
    mealy_state_t      w_nxt;

    mealy_code_lookup u_lookup (
        .code_i      (code),
        .legal_o     (w_legal),
        .src_state_o (w_src),
        .in_bit_o    (w_in_bit),
        .in_known_o  (w_in_known),
        .nxt_state_o (w_nxt)
    );

    // A code is only acted on when valid and not overridden by resync.
    logic              w_take;
    logic              w_consistent;
    logic [RUN_W-1:0]  w_run_next;
    logic              w_relock;

    assign w_take       = code_valid && !resync;
    assign w_consistent = w_legal && (w_src == trk_state_q);

    // While hunting, a legal code that does not follow from the tracked
    // state restarts the run at 1: it is taken as the new starting point
    // rather than counted as an error.
    assign w_run_next   = ((run_q == '0) || !w_consistent) ? RUN_W'(1)
                                                           : run_q + RUN_W'(1);
    assign w_relock     = (w_run_next >= c_LOCK_CNT);

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            // Source machine also resets to A, so start already locked.
            mode_q      <= TRK_LOCKED;
            run_q       <= '0;
            trk_state_q <= ST_A;
            bit_valid_q <= 1'b0;
            bit_out_q   <= 1'b0;
            bit_known_q <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            mode_q      <= mode_d;
            run_q       <= run_d;
            trk_state_q <= trk_state_d;
            bit_valid_q <= bit_valid_d;
            bit_out_q   <= bit_out_d;
            bit_known_q <= bit_known_d;
            err_q       <= err_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        mode_d      = mode_q;
        run_d       = run_q;
        trk_state_d = trk_state_q;
        if (resync) begin
            mode_d = TRK_HUNT;
            run_d  = '0;
        end else if (code_valid) begin
            case (mode_q)
                TRK_LOCKED: begin
                    if (w_consistent) begin
                        trk_state_d = w_nxt;
                    end else begin
                        // Tracked state is kept; the hunt re-derives it.
                        mode_d = TRK_HUNT;
                        run_d  = '0;
                    end
                end
                TRK_HUNT: begin
                    if (!w_legal) begin
                        run_d = '0;
                    end else begin
                        trk_state_d = w_nxt;
                        if (w_relock) begin
                            mode_d = TRK_LOCKED;
                            run_d  = '0;
                        end else begin
                            run_d = w_run_next;
                        end
                    end
                end
                default: begin
                    mode_d = TRK_HUNT;
                    run_d  = '0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Output logic (feeds the output registers)
    // ------------------------------------------------------------------
    always_comb begin
        bit_valid_d = 1'b0;
        bit_out_d   = 1'b0;
        bit_known_d = 1'b0;
        err_d       = 1'b0;
        if (w_take) begin
            case (mode_q)
                TRK_LOCKED: begin
                    if (w_consistent) begin
                        bit_valid_d = 1'b1;
                        bit_out_d   = w_in_bit;
                        bit_known_d = w_in_known;
                    end else begin
                        err_d = 1'b1;
                    end
                end
                TRK_HUNT: begin
                    if (!w_legal) begin
                        err_d = 1'b1;
                    end else if (w_relock) begin
                        // The code that completes the run emits its bit.
                        bit_valid_d = 1'b1;
                        bit_out_d   = w_in_bit;
                        bit_known_d = w_in_known;
                    end
                end
                default: begin
                    bit_valid_d = 1'b0;
                end
            endcase
        end
    end

    assign bit_valid = bit_valid_q;
    assign bit_out   = bit_out_q;
    assign bit_known = bit_known_q;
    assign err       = err_q;
    assign locked    = (mode_q == TRK_LOCKED);
    assign state_q   = trk_state_q;

`ifdef MEALY_TRK_STATS_EN
    // ------------------------------------------------------------------
    // Saturating statistics counters, updated on the same edge as the
    // bit_valid / err pulse they count.
    // ------------------------------------------------------------------
    logic [CNT_W-1:0] bit_cnt_q;
    logic [CNT_W-1:0] err_cnt_q;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            bit_cnt_q <= '0;
            err_cnt_q <= '0;
        end else begin
            if (bit_valid_d && (bit_cnt_q != '1)) begin
                bit_cnt_q <= bit_cnt_q + CNT_W'(1);
            end
            if (err_d && (err_cnt_q != '1)) begin
                err_cnt_q <= err_cnt_q + CNT_W'(1);
            end
        end
    end

    assign bit_cnt = bit_cnt_q;
    assign err_cnt = err_cnt_q;
`endif

endmodule : mealy_out_tracker

`default_nettype wire

// File: doc/mealy_out_tracker.md
# mealy_out_tracker

Observer for the 4-state Mealy sequence machine (states A=00, B=01, C=10, D=11) whose 3-bit transition outputs drive the front-panel LEDs. The tracker watches the stream of 3-bit output codes, reconstructs the machine's state, and recovers the input bit that caused each transition. It flags codes that are illegal or inconsistent with the tracked state, and it re-acquires lock after an error. It sits beside the machine as a checker, or at the far end of a link that carries only the output codes.

## Interface
- `LOCK_CNT`, default 2: consecutive consistent legal codes required to regain lock; legal range 1..15.
- `CNT_W`, default 8: width of the statistics counters.

Ports:
- `clk` in 1: single clock; all state changes on its rising edge.
- `reset_n` in 1: synchronous, active-low reset.
- `code_valid` in 1: `code` is valid this cycle.
- `code` in 3: observed transition output.
- `resync` in 1: force loss of lock.
- `bit_valid` out 1: recovered bit is presented this cycle.
- `bit_out` out 1: recovered input bit.
- `bit_known` out 1: recovered bit is determinate; 0 for transitions out of D.
- `err` out 1: one-cycle pulse on an illegal or inconsistent code.
- `locked` out 1: tracker is locked to the source.
- `state_q` out 2: tracked state (the state after the last accepted code).
- `bit_cnt` out CNT_W: recovered bits emitted; present only under the statistics macro.
- `err_cnt` out CNT_W: `err` pulses; present only under the statistics macro.

## Operation
Code table. Each legal code identifies its source state, the input bit and the next state uniquely:
- A: `111` gives in=0, next B; `101` gives in=1, next C.
- B: `001` gives in=0, next D; `011` gives in=1, next A.
- C: `000` gives in=0, next B; `100` gives in=1, next D.
- D: `110` gives in unknown, next D.
- `010` is illegal from every state.

Control FSM has two states, LOCKED and HUNT, plus a run counter.

LOCKED, on a valid code:
- Legal code whose source equals `state_q`: `state_q` takes the next state; `bit_valid`=1; `bit_out`=input bit; `bit_known`=0 only for `110`.
- Illegal code, or source not equal to `state_q`: `err`=1; go to HUNT with run=0; `state_q` is unchanged; no bit is emitted.

HUNT, on a valid code:
- Illegal code: `err`=1; run=0.
- Legal code with run=0, or with a source not equal to `state_q`: `state_q` takes the next state; run=1. The inconsistent case does not pulse `err`.
- Legal code consistent with `state_q`: `state_q` takes the next state; run increments.
- When run reaches `LOCK_CNT`: go to LOCKED, and the completing code emits its bit. With `LOCK_CNT`=1 the first legal code relocks immediately.
- No bits are emitted in HUNT otherwise.

Other rules:
- `code_valid`=0: `bit_valid`=0 and `err`=0; all state is held.
- `resync`=1: go to HUNT with run=0, whatever `code_valid` is. A code presented in the same cycle is dropped, with no bit and no `err`. `resync` has priority over everything except reset.
- `reset_n`=0 has top priority, including during a hunt.

## Timing
- All outputs are registered. A code sampled at edge k produces its `bit_*`, `err` and `state_q` after edge k. Latency is one cycle. Full throughput: one code per cycle, no backpressure.
- `locked` deasserts after the edge that samples the error. It reasserts after the edge that samples the `LOCK_CNT`-th consistent code.
- Reset values:
  - `bit_valid`, `bit_out`, `bit_known`, `err` = 0.
  - `locked` = 1 (LOCKED, since the source machine also resets to A).
  - `state_q` = A.
  - run = 0.
  - `bit_cnt` and `err_cnt` = 0.

## Configuration
- `MEALY_TRK_STATS_EN` defined:
  - `bit_cnt` increments on every `bit_valid`.
  - `err_cnt` increments on every `err`.
  - Both saturate at all-ones and never wrap.
  - Both clear only on reset.
- Not defined: both counter ports and their registers are absent; all other behaviour is identical.

## Structure
- Package `mealy_pkg` holds:
  - the state enum `mealy_state_t` (A, B, C, D with encodings 00, 01, 10, 11);
  - localparams for the seven legal codes and `CODE_ILLEGAL`=`3'b010`;
  - the control enum `trk_mode_t` (LOCKED, HUNT).
- Sub-module `mealy_code_lookup`: combinational; code in; outputs `legal`, `src_state`, `in_bit`, `in_known`, `nxt_state`. The tracker holds only the registers and the FSM.

## Test plan
- Reset, then codes `111`,`001`,`110`,`110`: bits 0,0 with `bit_known`=1, then two bits with `bit_known`=0; `state_q` A→B→D→D→D; `err`=0 throughout.
- From A, codes `101`,`000`,`011`: bits 1,0,1; `state_q` C,B,A; `locked` stays 1.
- From A, code `001`: `err` pulse, `locked`=0, no bit. Then `000`: no bit, `state_q`=B. Then `011`: bit 1, `locked`=1, `state_q`=A.
- Code `010` while locked: `err`=1, `locked`=0. Then `010` again: second `err`, run stays 0. With the macro, `err_cnt`=2.
- `resync`=1 with `code_valid`=1 and `code`=`111` in the same cycle: code dropped, `bit_valid`=0, `err`=0, `locked`=0. Hunt `111`,`001` then relocks with the bit emitted for `001`.
- `CNT_W`=2 with the macro: five legal consistent codes give `bit_cnt`=3 (saturated). Then reset mid-stream: all outputs return to their reset values after the next edge.
